trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//   Sequences machine-mode trap entry and MRET for the core. It sits between the CSR block and the fetch/pipeline control.
//   - Detects enabled interrupts and reported exceptions, then prioritises and latches the cause.
//   - Flushes the pipeline and issues one atomic CSR update (mepc/mcause/mtval/mstatus).
//   - Redirects the PC to the trap vector, or to mepc on MRET.
// PARAMETERS
//   NUM_IRQ       8   number of interrupt lines (mip/mie bits [NUM_IRQ-1:0]), 1..16
//   FLUSH_CYCLES  2   cycles flush_o is held before the CSR update, >=1
// PORTS
//   clk            in   1   core clock, rising edge
//   reset_n        in   1   asynchronous, active-low reset
//   mip_i          in   32  pending interrupts
//   mie_i          in   32  interrupt enables
//   mstatus_mie_i  in   1   global machine interrupt enable (MIE)
//   mstatus_mpie_i in   1   current MPIE
//   mtvec_i        in   32  trap vector; bit0=1 selects vectored mode
//   mepc_i         in   32  current mepc (MRET target)
//   exc_valid_i    in   1   exception reported; held by source until trap_ack_o
//   exc_code_i     in   5   exception cause (trap_pkg codes)
//   exc_tval_i     in   32  faulting address/instruction
//   pc_i           in   32  PC of faulting instr (exception) or next instr (interrupt)
//   mret_i         in   1   MRET retiring, single-cycle pulse
//   busy_o         out  1   sequencer not IDLE; the pipeline must not retire instructions
//   flush_o        out  1   kill in-flight instructions
//   csr_we_o       out  1   one-cycle strobe: write mepc/mcause/mtval/mstatus fields
//   mepc_o         out  32  value to write to mepc
//   mcause_o       out  32  {is_irq, 26'b0, code[4:0]}
//   mtval_o        out  32  exc_tval, or 0 for interrupts
//   mie_o          out  1   new MIE value
//   mpie_o         out  1   new MPIE value
//   redirect_o     out  1   one-cycle PC redirect strobe
//   redirect_pc_o  out  32  redirect target
//   trap_ack_o     out  1   one-cycle pulse, coincident with csr_we_o on trap entry
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; latched cause/pc/tval cleared. Reset mid-sequence aborts it immediately.
//     No CSR write or redirect is emitted after reset deasserts.
//   Interrupt eligibility: irq = |(mip_i & mie_i & NUM_IRQ mask) & mstatus_mie_i.
//   IRQ priority: lowest set bit index wins; code = bit index.
//   Arbitration in IDLE, evaluated each cycle:
//     exc_valid_i > mret_i > irq. mret_i with exc_valid_i: the MRET is dropped.
//   State transitions:
//     IDLE -> FLUSH on exception or irq. Latch is_irq, code, pc_i, and tval (exc_tval_i, or 0 for irq).
//     FLUSH: flush_o=1 for FLUSH_CYCLES cycles (down-counter), then -> SAVE.
//     SAVE (1 cycle): flush_o=1, csr_we_o=1, trap_ack_o=1.
//       Outputs: mepc_o=latched pc with bits[1:0] forced 0; mie_o=0; mpie_o=mstatus_mie_i.
//       Next state -> REDIR.
//     REDIR (1 cycle): redirect_o=1. Target base={mtvec_i[31:2],2'b00}.
//       redirect_pc_o = base + (code<<2) if mtvec_i[0] && is_irq; otherwise base. Arithmetic is mod 2^32.
//       Next state -> IDLE.
//     IDLE -> RET on mret_i (no exception).
//     RET (1 cycle): csr_we_o=1, mie_o=mstatus_mpie_i, mpie_o=1; mepc_o=mepc_i, mcause_o/mtval_o unchanged.
//       Same cycle: redirect_o=1, redirect_pc_o={mepc_i[31:2],2'b00}. Next state -> IDLE.
//       The write-enable only covers mstatus on RET; the CSR block ignores mepc/mcause/mtval writes when the trap_ack_o pulse is 0.
//   Latency: trap seen at cycle N -> csr_we at N+FLUSH_CYCLES+1 -> redirect at N+FLUSH_CYCLES+2.
//     MRET seen at N -> update and redirect at N+1.
//   Events outside IDLE are ignored. Interrupts stay pending as levels.
//     The exception source holds exc_valid_i until trap_ack_o.
//     An irq arriving with MRET is taken after RET, once the restored MIE allows it.
//   Inputs are sampled only in IDLE; mtvec_i is sampled again in REDIR.
//   busy_o=1 in every state except IDLE.
// STRUCTURE
//   trap_pkg: state enum {IDLE,FLUSH,SAVE,REDIR,RET}.
//     Exception codes: EXC_INST_MISALIGN=0, EXC_ILLEGAL=2, EXC_LOAD_MISALIGN=4, EXC_STORE_MISALIGN=6.
//     Also the MCAUSE_IRQ_BIT=31 constant.
//   Sub-module irq_prio_enc (NUM_IRQ): combinational lowest-index encoder. Outputs valid and code[4:0].
//   The top level holds the FSM, flush counter, and cause/pc/tval latches.
// TESTING
//   1. Reset mid-FLUSH (assert reset_n=0 during FLUSH) -> all outputs 0 at once; no csr_we or redirect after release.
//   2. Illegal instr: exc_valid=1, code=2, pc=0x100, tval=0xDEADBEEF, mtvec=0x1001.
//      -> flush 3 cycles, then csr_we with mepc=0x100, mcause=0x2, mtval=0xDEADBEEF.
//      -> redirect to 0x1000; exceptions are not vectored.
//   3. mip=mie=0x88, MIE=1, mtvec=0x2001, pc=0x40 -> mcause=0x80000003, mtval=0, mie_o=0, redirect to 0x200C.
//   4. mip=0x80, mie=0x80, MIE=0 -> no trap. Raise MIE -> trap taken; mcause=0x80000007, redirect to 0x2000 when mtvec=0x2000.
//   5. Same cycle: exc_valid and irq -> exception cause written; irq taken after the sequence returns to IDLE.
//      Same cycle: mret and exc_valid -> exception taken, no RET.
//   6. mret with MPIE=1, mepc=0x300 -> next cycle csr_we, mie_o=1, mpie_o=1, redirect to 0x300.
//      Then a pending enabled irq is taken from IDLE.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned CODE_W         = 5;
  localparam int unsigned MCAUSE_IRQ_BIT = 31;

  localparam logic [CODE_W-1:0] EXC_INST_MISALIGN  = 5'd0;
  localparam logic [CODE_W-1:0] EXC_ILLEGAL        = 5'd2;
  localparam logic [CODE_W-1:0] EXC_LOAD_MISALIGN  = 5'd4;
  localparam logic [CODE_W-1:0] EXC_STORE_MISALIGN = 5'd6;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SAVE,
    REDIR,
    RET
  } state_e;

  // Cause captured at trap detection; pc is word-aligned so only [31:2] is kept.
  typedef struct packed {
    logic              is_irq;
    logic [CODE_W-1:0] code;
    logic [XLEN-1:2]   pc;
    logic [XLEN-1:0]   tval;
    logic              mpie;
  } trap_cause_t;

  function automatic logic [XLEN-1:0] mcause_of(input trap_cause_t c);
    logic [XLEN-1:0] r;
    r                 = XLEN'(c.code);
    r[MCAUSE_IRQ_BIT] = c.is_irq;
    return r;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins interrupt priority encoder.
module irq_prio_enc
  import trap_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [CODE_W-1:0]  code
);

  logic found;

  always_comb begin
    valid = |req;
    code  = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (req[i] && !found) begin
        code  = CODE_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: arbitrate, flush, update CSRs, redirect PC.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned NUM_IRQ      = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   mip_i,
  input  logic [XLEN-1:0]   mie_i,
  input  logic              mstatus_mie_i,
  input  logic              mstatus_mpie_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic              exc_valid_i,
  input  logic [CODE_W-1:0] exc_code_i,
  input  logic [XLEN-1:0]   exc_tval_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              mret_i,
  output logic              busy_o,
  output logic              flush_o,
  output logic              csr_we_o,
  output logic [XLEN-1:0]   mepc_o,
  output logic [XLEN-1:0]   mcause_o,
  output logic [XLEN-1:0]   mtval_o,
  output logic              mie_o,
  output logic              mpie_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              trap_ack_o
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  trap_cause_t       cause_q, cause_d;

  logic              busy_d, flush_d, csr_we_d, redirect_d, trap_ack_d, mie_d, mpie_d;
  logic [XLEN-1:0]   mepc_d, mcause_d, mtval_d, redirect_pc_d;

  logic              irq_valid;
  logic [CODE_W-1:0] irq_code;
  logic              irq;
  logic [XLEN-1:0]   vec_base;

  logic              unused_bits;
  assign unused_bits = ^{mip_i[XLEN-1:NUM_IRQ], mie_i[XLEN-1:NUM_IRQ], mtvec_i[1], pc_i[1:0]};

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_prio (
    .req  (mip_i[NUM_IRQ-1:0] & mie_i[NUM_IRQ-1:0]),
    .valid(irq_valid),
    .code (irq_code)
  );

  assign irq      = irq_valid & mstatus_mie_i;
  assign vec_base = {mtvec_i[XLEN-1:2], 2'b00};

  // Next state, cause latch, and the registered outputs of the state being entered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    flush_d       = 1'b0;
    csr_we_d      = 1'b0;
    redirect_d    = 1'b0;
    trap_ack_d    = 1'b0;
    mepc_d        = mepc_o;
    mcause_d      = mcause_o;
    mtval_d       = mtval_o;
    mie_d         = mie_o;
    mpie_d        = mpie_o;
    redirect_pc_d = redirect_pc_o;

    unique case (state_q)
      IDLE: begin
        if (exc_valid_i) begin
          state_d        = FLUSH;
          cnt_d          = CNT_W'(FLUSH_CYCLES - 1);
          cause_d.is_irq = 1'b0;
          cause_d.code   = exc_code_i;
          cause_d.pc     = pc_i[XLEN-1:2];
          cause_d.tval   = exc_tval_i;
          cause_d.mpie   = mstatus_mie_i;
        end else if (mret_i) begin
          state_d = RET;
        end else if (irq) begin
          state_d        = FLUSH;
          cnt_d          = CNT_W'(FLUSH_CYCLES - 1);
          cause_d.is_irq = 1'b1;
          cause_d.code   = irq_code;
          cause_d.pc     = pc_i[XLEN-1:2];
          cause_d.tval   = '0;
          cause_d.mpie   = mstatus_mie_i;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = SAVE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SAVE:    state_d = REDIR;
      REDIR:   state_d = IDLE;
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    unique case (state_d)
      FLUSH: flush_d = 1'b1;
      SAVE: begin
        flush_d    = 1'b1;
        csr_we_d   = 1'b1;
        trap_ack_d = 1'b1;
        mepc_d     = {cause_q.pc, 2'b00};
        mcause_d   = mcause_of(cause_q);
        mtval_d    = cause_q.tval;
        mie_d      = 1'b0;
        mpie_d     = cause_q.mpie;
      end
      REDIR: begin
        redirect_d    = 1'b1;
        redirect_pc_d = (mtvec_i[0] && cause_q.is_irq)
                        ? vec_base + XLEN'({cause_q.code, 2'b00})
                        : vec_base;
      end
      RET: begin
        csr_we_d      = 1'b1;
        mie_d         = mstatus_mpie_i;
        mpie_d        = 1'b1;
        mepc_d        = mepc_i;
        redirect_d    = 1'b1;
        redirect_pc_d = {mepc_i[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cause_q       <= '0;
      busy_o        <= 1'b0;
      flush_o       <= 1'b0;
      csr_we_o      <= 1'b0;
      redirect_o    <= 1'b0;
      trap_ack_o    <= 1'b0;
      mepc_o        <= '0;
      mcause_o      <= '0;
      mtval_o       <= '0;
      mie_o         <= 1'b0;
      mpie_o        <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cause_q       <= cause_d;
      busy_o        <= busy_d;
      flush_o       <= flush_d;
      csr_we_o      <= csr_we_d;
      redirect_o    <= redirect_d;
      trap_ack_o    <= trap_ack_d;
      mepc_o        <= mepc_d;
      mcause_o      <= mcause_d;
      mtval_o       <= mtval_d;
      mie_o         <= mie_d;
      mpie_o        <= mpie_d;
      redirect_pc_o <= redirect_pc_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: vector table plus scoreboard of CSR writes and redirects.
module tb_trap_sequencer;

  localparam int unsigned F = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mip, mie, mtvec, mepc, exc_tval, pc;
  logic        smie, smpie, exc_valid, mret;
  logic [4:0]  exc_code;
  logic        busy_o, flush_o, csr_we_o, mie_o, mpie_o, redirect_o, trap_ack_o;
  logic [31:0] mepc_o, mcause_o, mtval_o, redirect_pc_o;

  trap_sequencer #(.NUM_IRQ(8), .FLUSH_CYCLES(F)) dut (
    .clk(clk), .reset_n(reset_n),
    .mip_i(mip), .mie_i(mie), .mstatus_mie_i(smie), .mstatus_mpie_i(smpie),
    .mtvec_i(mtvec), .mepc_i(mepc), .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .exc_tval_i(exc_tval), .pc_i(pc), .mret_i(mret),
    .busy_o(busy_o), .flush_o(flush_o), .csr_we_o(csr_we_o), .mepc_o(mepc_o),
    .mcause_o(mcause_o), .mtval_o(mtval_o), .mie_o(mie_o), .mpie_o(mpie_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .trap_ack_o(trap_ack_o)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NONE, K_TRAP, K_RET} kind_e;

  typedef struct {
    kind_e       kind;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] tval, pc, mip, mie;
    logic        smie, smpie;
    logic [31:0] mtvec, mepc;
    logic        mret;
    logic [31:0] e_mepc, e_mcause, e_mtval;
    logic        e_mie, e_mpie;
    logic [31:0] e_rpc;
  } vec_t;

  typedef struct {
    logic [31:0] mepc, mcause, mtval;
    logic        mie, mpie, ack;
  } csr_exp_t;

  csr_exp_t    exp_csr[$];
  logic [31:0] exp_redir[$];
  csr_exp_t    mon_e;
  logic [31:0] mon_r;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] m, c, t, input logic ie, pie, ack, input logic [31:0] rpc);
    csr_exp_t e;
    e.mepc = m; e.mcause = c; e.mtval = t; e.mie = ie; e.mpie = pie; e.ack = ack;
    exp_csr.push_back(e);
    exp_redir.push_back(rpc);
  endtask

  // Scoreboard: every CSR write and redirect must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (csr_we_o) begin
        if (exp_csr.size() == 0) check("spurious_csr_we", 32'(csr_we_o), 32'd0);
        else begin
          mon_e = exp_csr.pop_front();
          check("mepc_o", mepc_o, mon_e.mepc);
          check("mcause_o", mcause_o, mon_e.mcause);
          check("mtval_o", mtval_o, mon_e.mtval);
          check("mie_o", 32'(mie_o), 32'(mon_e.mie));
          check("mpie_o", 32'(mpie_o), 32'(mon_e.mpie));
          check("trap_ack_o", 32'(trap_ack_o), 32'(mon_e.ack));
        end
      end else if (trap_ack_o) begin
        check("ack_without_csr_we", 32'(csr_we_o), 32'd1);
      end
      if (redirect_o) begin
        if (exp_redir.size() == 0) check("spurious_redirect", 32'(redirect_o), 32'd0);
        else begin
          mon_r = exp_redir.pop_front();
          check("redirect_pc_o", redirect_pc_o, mon_r);
        end
      end
    end
  end

  task automatic set_idle();
    exc_valid = 1'b0; exc_code = '0; exc_tval = '0; pc = '0;
    mip = '0; mie = '0; smie = 1'b0; smpie = 1'b0; mret = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int csr_at, red_at, nflush;
    @(negedge clk);
    exc_valid = v.exc; exc_code = v.code; exc_tval = v.tval; pc = v.pc;
    mip = v.mip; mie = v.mie; smie = v.smie; smpie = v.smpie;
    mtvec = v.mtvec; mepc = v.mepc; mret = v.mret;
    if (v.kind != K_NONE)
      push_exp(v.e_mepc, v.e_mcause, v.e_mtval, v.e_mie, v.e_mpie, v.kind == K_TRAP, v.e_rpc);
    csr_at = 0; red_at = 0; nflush = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) mret = 1'b0;
      if (flush_o) nflush++;
      if (csr_we_o && csr_at == 0) csr_at = c;
      if (redirect_o && red_at == 0) red_at = c;
      if (trap_ack_o) begin exc_valid = 1'b0; mip = '0; end
    end
    case (v.kind)
      K_TRAP: begin
        check($sformatf("v%0d_csr_latency", idx), 32'(csr_at), 32'(F + 1));
        check($sformatf("v%0d_redir_latency", idx), 32'(red_at), 32'(F + 2));
        check($sformatf("v%0d_flush_cycles", idx), 32'(nflush), 32'(F + 1));
      end
      K_RET: begin
        check($sformatf("v%0d_csr_latency", idx), 32'(csr_at), 32'd1);
        check($sformatf("v%0d_redir_latency", idx), 32'(red_at), 32'd1);
        check($sformatf("v%0d_flush_cycles", idx), 32'(nflush), 32'd0);
      end
      default: begin
        check($sformatf("v%0d_no_csr", idx), 32'(csr_at), 32'd0);
        check($sformatf("v%0d_no_redir", idx), 32'(red_at), 32'd0);
      end
    endcase
    check($sformatf("v%0d_busy_end", idx), 32'(busy_o), 32'd0);
    set_idle();
  endtask

  vec_t vecs[10];

  initial begin
    int acks, reds, cnt;
    vecs[0] = '{K_TRAP, 1, 5'd2, 32'hDEADBEEF, 32'h100, 0, 0, 1, 0, 32'h1001, 0, 0,
                32'h100, 32'h2, 32'hDEADBEEF, 0, 1, 32'h1000};
    vecs[1] = '{K_TRAP, 0, 5'd0, 0, 32'h40, 32'h88, 32'h88, 1, 0, 32'h2001, 0, 0,
                32'h40, 32'h80000003, 0, 0, 1, 32'h200C};
    vecs[2] = '{K_NONE, 0, 5'd0, 0, 32'h40, 32'h80, 32'h80, 0, 0, 32'h2000, 0, 0,
                0, 0, 0, 0, 0, 0};
    vecs[3] = '{K_TRAP, 0, 5'd0, 0, 32'h44, 32'h80, 32'h80, 1, 0, 32'h2000, 0, 0,
                32'h44, 32'h80000007, 0, 0, 1, 32'h2000};
    vecs[4] = '{K_RET, 0, 5'd0, 0, 0, 0, 0, 0, 1, 32'h2000, 32'h300, 1,
                32'h300, 32'h80000007, 0, 1, 1, 32'h300};
    vecs[5] = '{K_TRAP, 1, 5'd4, 32'h103, 32'h103, 0, 0, 0, 0, 32'h1001, 0, 0,
                32'h100, 32'h4, 32'h103, 0, 0, 32'h1000};
    vecs[6] = '{K_NONE, 0, 5'd0, 0, 0, 32'h100, 32'h100, 1, 0, 32'h2001, 0, 0,
                0, 0, 0, 0, 0, 0};
    vecs[7] = '{K_TRAP, 1, 5'd6, 32'h55, 32'h200, 0, 0, 0, 1, 32'h2001, 32'h300, 1,
                32'h200, 32'h6, 32'h55, 0, 0, 32'h2000};
    vecs[8] = '{K_RET, 0, 5'd0, 0, 0, 0, 0, 0, 0, 32'h2001, 32'h403, 1,
                32'h403, 32'h6, 32'h55, 0, 1, 32'h400};
    vecs[9] = '{K_TRAP, 0, 5'd0, 0, 32'h82, 32'hF0, 32'hA0, 1, 0, 32'hFFFFFFFD, 0, 0,
                32'h80, 32'h80000005, 0, 0, 1, 32'h10};

    reset_n = 1'b0; mtvec = '0; mepc = '0;
    set_idle();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_flush", 32'(flush_o), 0);
    check("rst_csr_we", 32'(csr_we_o), 0);
    check("rst_redirect", 32'(redirect_o), 0);
    check("rst_mcause", mcause_o, 0);
    reset_n = 1'b1;

    // Reset during FLUSH aborts the trap with no later CSR write or redirect.
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd2; pc = 32'h100; exc_tval = 32'hDEADBEEF; mtvec = 32'h1001;
    @(negedge clk);
    check("midflush_flush", 32'(flush_o), 1);
    check("midflush_busy", 32'(busy_o), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_flush", 32'(flush_o), 0);
    check("rst_async_busy", 32'(busy_o), 0);
    check("rst_async_csr_we", 32'(csr_we_o), 0);
    check("rst_async_redirect", 32'(redirect_o), 0);
    exc_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (csr_we_o || redirect_o) cnt++;
    end
    check("no_update_after_reset", 32'(cnt), 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Exception and interrupt together: exception first, interrupt once back in IDLE.
    @(negedge clk);
    exc_valid = 1'b1; exc_code = 5'd2; exc_tval = 32'h11; pc = 32'h10;
    mip = 32'h2; mie = 32'h2; smie = 1'b1; mtvec = 32'h3001;
    push_exp(32'h10, 32'h2, 32'h11, 0, 1, 1, 32'h3000);
    push_exp(32'h10, 32'h80000001, 32'h0, 0, 1, 1, 32'h3004);
    acks = 0; reds = 0;
    for (int c = 1; c <= 30 && reds < 2; c++) begin
      @(negedge clk);
      if (trap_ack_o) begin
        acks++;
        exc_valid = 1'b0;
        if (acks == 2) mip = '0;
      end
      if (redirect_o) reds++;
    end
    check("exc_irq_acks", 32'(acks), 2);
    check("exc_irq_redirects", 32'(reds), 2);
    set_idle();
    repeat (2) @(negedge clk);

    // MRET restores MIE; the pending interrupt is then taken from IDLE.
    @(negedge clk);
    mip = 32'h4; mie = 32'h4; smie = 1'b0; smpie = 1'b1;
    mepc = 32'h300; pc = 32'h300; mtvec = 32'h2001; mret = 1'b1;
    push_exp(32'h300, 32'h80000001, 32'h0, 1, 1, 0, 32'h300);
    push_exp(32'h300, 32'h80000002, 32'h0, 0, 1, 1, 32'h2008);
    @(negedge clk);
    mret = 1'b0;
    check("ret_csr_we", 32'(csr_we_o), 1);
    check("ret_redirect", 32'(redirect_o), 1);
    smie = 1'b1;
    reds = 0;
    for (int c = 1; c <= 20 && reds < 1; c++) begin
      @(negedge clk);
      if (trap_ack_o) mip = '0;
      if (redirect_o) reds++;
    end
    check("post_ret_irq_redirect", 32'(reds), 1);
    set_idle();
    repeat (3) @(negedge clk);

    check("csr_exp_left", 32'(exp_csr.size()), 0);
    check("redir_exp_left", 32'(exp_redir.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
